// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: shares the register-file write port between the in-order
// writeback stage and buffered long-latency (mul/div) results. It keeps a
// scoreboard of destinations with outstanding long results, which drives the
// decode stall, and a starvation counter so that a steady stream of writebacks
// cannot hold a buffered result off the port for more than STARVE_LIMIT cycles.
module reg_write_arbiter #(
   parameter int DATA_W       = 32,
   parameter int BUF_DEPTH    = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wbValid,
   input  logic [4:0]        wbReg,
   input  logic [DATA_W-1:0] wbData,
   output logic              wbHold,
   input  logic              lrIssue,
   input  logic [4:0]        lrIssueReg,
   input  logic              lrValid,
   input  logic [4:0]        lrReg,
   input  logic [DATA_W-1:0] lrData,
   output logic              lrReady,
   input  logic [4:0]        readReg1,
   input  logic [4:0]        readReg2,
   output logic              stall,
   output logic [31:0]       pendingMask,
   output logic              write,
   output logic [4:0]        writeReg,
   output logic [DATA_W-1:0] writeData
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

   logic [4:0]        buf_reg  [BUF_DEPTH];
   logic [DATA_W-1:0] buf_data [BUF_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [AGE_W-1:0]  age;
   logic [31:0]       mask_next;

   logic buf_non_empty, buf_full, starve, push, pop, sel_wb;
   logic [4:0]        head_reg;
   logic [DATA_W-1:0] head_data;

   assign buf_non_empty = (count != '0);
   assign buf_full      = (count == CNT_W'(BUF_DEPTH));
   assign head_reg      = buf_reg[rd_ptr];
   assign head_data     = buf_data[rd_ptr];
   assign starve        = buf_non_empty && (age == AGE_W'(STARVE_LIMIT));

   // lrReady comes only from registered occupancy, so lrValid never loops back to it.
   assign lrReady = !buf_full;
   assign push    = lrValid && lrReady;
   assign pop     = starve || (!wbValid && buf_non_empty);
   assign sel_wb  = wbValid && !starve;
   assign wbHold  = wbValid && starve;

   assign stall = ((readReg1 != 5'd0) && pendingMask[readReg1]) ||
                  ((readReg2 != 5'd0) && pendingMask[readReg2]);

   // Buffer storage; contents are don't-care while not counted as occupied.
   always_ff @(posedge clk) begin
      if (push) begin
         buf_reg[wr_ptr]  <= lrReg;
         buf_data[wr_ptr] <= lrData;
      end
   end

   // Buffer pointers, occupancy and head age (restarts whenever a new head takes over).
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         age    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push) - CNT_W'(pop);
         if (pop || !buf_non_empty)
            age <= '0;
         else if (age != AGE_W'(STARVE_LIMIT))
            age <= age + 1'b1;
      end
   end

   // Scoreboard next value: a new issue outranks the clear from a same-register pop.
   always_comb begin
      mask_next = pendingMask;
      if (pop)
         mask_next[head_reg] = 1'b0;
      if (lrIssue && (lrIssueReg != 5'd0))
         mask_next[lrIssueReg] = 1'b1;
   end

   // Scoreboard register.
   always_ff @(posedge clk) begin
      if (rst) pendingMask <= '0;
      else     pendingMask <= mask_next;
   end

   // Registered write port; r0 targets are consumed but never strobe write.
   always_ff @(posedge clk) begin
      if (rst) begin
         write     <= 1'b0;
         writeReg  <= '0;
         writeData <= '0;
      end else if (pop) begin
         write     <= (head_reg != 5'd0);
         writeReg  <= head_reg;
         writeData <= head_data;
      end else if (sel_wb) begin
         write     <= (wbReg != 5'd0);
         writeReg  <= wbReg;
         writeData <= wbData;
      end else begin
         write <= 1'b0;
      end
   end

endmodule
